// File: rtl/execute_pipe.sv
// Y86-64 execute stage: ALU, condition-code register, cnd resolution for
// jxx/cmovxx, an optional iterative shift-add multiplier, and the E->M
// pipeline register.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   E_stat/E_icode/E_ifun             instruction in E
//   E_valA/E_valB/E_valC              operands
//   E_dstE/E_dstM                     destination register IDs (4'hF = none)
//   m_stat/W_stat                     later-stage stats for CC suppression
//   M_bubble                          force a bubble into M at the next edge
//   e_valE/e_dstE/e_cnd               combinational forwarding outputs
//   e_busy                            stall request while a mul is in flight
//   cc                                registered {ZF, SF, OF}
//   M_*                               E->M pipeline register
module execute_pipe #(
  parameter int unsigned WIDTH  = 64,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       E_stat,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_ifun,
  input  logic [WIDTH-1:0] E_valA,
  input  logic [WIDTH-1:0] E_valB,
  input  logic [WIDTH-1:0] E_valC,
  input  logic [3:0]       E_dstE,
  input  logic [3:0]       E_dstM,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  input  logic             M_bubble,
  output logic [WIDTH-1:0] e_valE,
  output logic [3:0]       e_dstE,
  output logic             e_cnd,
  output logic             e_busy,
  output logic [2:0]       cc,
  output logic [2:0]       M_stat,
  output logic [3:0]       M_icode,
  output logic             M_cnd,
  output logic [WIDTH-1:0] M_valE,
  output logic [WIDTH-1:0] M_valA,
  output logic [3:0]       M_dstE,
  output logic [3:0]       M_dstM
);

  localparam logic [2:0] StatAok = 3'd1;
  localparam logic [2:0] StatIns = 3'd4;
  localparam logic [3:0] RegNone = 4'hF;
  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} mul_state_e;

  mul_state_e       state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             mul_busy;
  logic             is_mul;

  logic [2:0]       cc_q;
  logic             cc_we;
  logic [WIDTH-1:0] op_res;
  logic             op_valid;
  logic             op_of;
  logic             zf, sf, of;

  assign is_mul = MUL_EN && (E_icode == 4'h6) && (E_ifun == 4'h4);

  // Multiplier FSM; operands are captured on entry to RUN so the result does
  // not depend on E being held perfectly stable.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mul_busy = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (is_mul) begin
          mul_busy = 1'b1;
          mcand_d  = E_valB;
          mplier_d = E_valA;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        mul_busy = 1'b1;
        // Low WIDTH bits of a two's-complement product equal the unsigned one.
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  // Gated by reset so a held mul in E cannot stall upstream during reset.
  assign e_busy = rst_n & mul_busy;

  // OPq datapath and flags.
  always_comb begin
    op_res   = '0;
    op_valid = 1'b1;
    op_of    = 1'b0;
    case (E_ifun)
      4'h0: begin
        op_res = E_valB + E_valA;
        op_of  = (E_valA[WIDTH-1] == E_valB[WIDTH-1]) &&
                 (op_res[WIDTH-1] != E_valB[WIDTH-1]);
      end
      4'h1: begin
        op_res = E_valB - E_valA;
        op_of  = (E_valA[WIDTH-1] != E_valB[WIDTH-1]) &&
                 (op_res[WIDTH-1] != E_valB[WIDTH-1]);
      end
      4'h2: op_res = E_valB & E_valA;
      4'h3: op_res = E_valB ^ E_valA;
      4'h4: begin
        op_valid = MUL_EN;
        op_res   = (MUL_EN && state_q == StDone) ? acc_q : '0;
      end
      default: op_valid = 1'b0;
    endcase
  end

  always_comb begin
    e_valE = '0;
    case (E_icode)
      4'h2:       e_valE = E_valA;
      4'h3:       e_valE = E_valC;
      4'h4, 4'h5: e_valE = E_valB + E_valC;
      4'h6:       e_valE = op_res;
      4'h8, 4'hA: e_valE = E_valB - WIDTH'(8);
      4'h9, 4'hB: e_valE = E_valB + WIDTH'(8);
      default:    e_valE = '0;
    endcase
  end

  assign zf = cc_q[2];
  assign sf = cc_q[1];
  assign of = cc_q[0];

  always_comb begin
    e_cnd = 1'b0;
    case (E_ifun)
      4'h0:    e_cnd = 1'b1;
      4'h1:    e_cnd = (sf ^ of) | zf;
      4'h2:    e_cnd = sf ^ of;
      4'h3:    e_cnd = zf;
      4'h4:    e_cnd = ~zf;
      4'h5:    e_cnd = ~(sf ^ of);
      4'h6:    e_cnd = ~((sf ^ of) | zf);
      default: e_cnd = 1'b0;
    endcase
  end

  assign e_dstE = ((E_icode == 4'h2) && !e_cnd) ? RegNone : E_dstE;

  assign cc_we = (E_icode == 4'h6) && op_valid && !e_busy &&
                 (E_stat == StatAok) && (m_stat == StatAok) && (W_stat == StatAok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_q <= 3'b100;
    end else if (cc_we) begin
      cc_q <= {op_res == '0, op_res[WIDTH-1], op_of};
    end
  end

  assign cc = cc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      M_stat  <= StatAok;
      M_icode <= 4'h1;
      M_cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= RegNone;
      M_dstM  <= RegNone;
    end else if (M_bubble || e_busy) begin
      M_stat  <= StatAok;
      M_icode <= 4'h1;
      M_cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= RegNone;
      M_dstM  <= RegNone;
    end else begin
      M_stat  <= ((E_icode == 4'h6) && !op_valid) ? StatIns : E_stat;
      M_icode <= E_icode;
      M_cnd   <= e_cnd;
      M_valE  <= e_valE;
      M_valA  <= E_valA;
      M_dstE  <= e_dstE;
      M_dstM  <= E_dstM;
    end
  end

endmodule

// File: tb/tb_execute_pipe.sv
module tb_execute_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  E_stat, m_stat, W_stat;
  logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM;
  logic [63:0] E_valA, E_valB, E_valC;
  logic        M_bubble;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // 64-bit instance
  logic [63:0] a_valE, a_MvalE, a_MvalA;
  logic [3:0]  a_dstE, a_Micode, a_MdstE, a_MdstM;
  logic        a_cnd, a_busy, a_Mcnd;
  logic [2:0]  a_cc, a_Mstat;

  execute_pipe #(.WIDTH(64), .MUL_EN(1'b1)) u64 (
    .clk(clk), .rst_n(rst_n), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC), .E_dstE(E_dstE), .E_dstM(E_dstM),
    .m_stat(m_stat), .W_stat(W_stat), .M_bubble(M_bubble),
    .e_valE(a_valE), .e_dstE(a_dstE), .e_cnd(a_cnd), .e_busy(a_busy), .cc(a_cc),
    .M_stat(a_Mstat), .M_icode(a_Micode), .M_cnd(a_Mcnd), .M_valE(a_MvalE),
    .M_valA(a_MvalA), .M_dstE(a_MdstE), .M_dstM(a_MdstM)
  );

  // 16-bit instance with multiplier
  logic [15:0] b_valE, b_MvalE, b_MvalA;
  logic [3:0]  b_dstE, b_Micode, b_MdstE, b_MdstM;
  logic        b_cnd, b_busy, b_Mcnd;
  logic [2:0]  b_cc, b_Mstat;

  execute_pipe #(.WIDTH(16), .MUL_EN(1'b1)) u16 (
    .clk(clk), .rst_n(rst_n), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valA(E_valA[15:0]), .E_valB(E_valB[15:0]), .E_valC(E_valC[15:0]),
    .E_dstE(E_dstE), .E_dstM(E_dstM),
    .m_stat(m_stat), .W_stat(W_stat), .M_bubble(M_bubble),
    .e_valE(b_valE), .e_dstE(b_dstE), .e_cnd(b_cnd), .e_busy(b_busy), .cc(b_cc),
    .M_stat(b_Mstat), .M_icode(b_Micode), .M_cnd(b_Mcnd), .M_valE(b_MvalE),
    .M_valA(b_MvalA), .M_dstE(b_MdstE), .M_dstM(b_MdstM)
  );

  // 16-bit instance without multiplier
  logic [15:0] c_valE, c_MvalE, c_MvalA;
  logic [3:0]  c_dstE, c_Micode, c_MdstE, c_MdstM;
  logic        c_cnd, c_busy, c_Mcnd;
  logic [2:0]  c_cc, c_Mstat;

  execute_pipe #(.WIDTH(16), .MUL_EN(1'b0)) u16n (
    .clk(clk), .rst_n(rst_n), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valA(E_valA[15:0]), .E_valB(E_valB[15:0]), .E_valC(E_valC[15:0]),
    .E_dstE(E_dstE), .E_dstM(E_dstM),
    .m_stat(m_stat), .W_stat(W_stat), .M_bubble(M_bubble),
    .e_valE(c_valE), .e_dstE(c_dstE), .e_cnd(c_cnd), .e_busy(c_busy), .cc(c_cc),
    .M_stat(c_Mstat), .M_icode(c_Micode), .M_cnd(c_Mcnd), .M_valE(c_MvalE),
    .M_valA(c_MvalA), .M_dstE(c_MdstE), .M_dstM(c_MdstM)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_e(input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [63:0] va, input logic [63:0] vb,
                       input logic [63:0] vc, input logic [3:0] dste);
    E_stat  = 3'd1;
    E_icode = icode;
    E_ifun  = ifun;
    E_valA  = va;
    E_valB  = vb;
    E_valC  = vc;
    E_dstE  = dste;
    E_dstM  = 4'hF;
  endtask

  // Waits while the 16-bit multiplier is busy; returns the number of busy cycles.
  task automatic wait_busy16(output int n, output int nonbubble);
    n = 0;
    nonbubble = 0;
    while (b_busy && n < 40) begin
      n++;
      step();
      if (b_Micode !== 4'h1) nonbubble++;
    end
  endtask

  task automatic test_reset();
    m_stat = 3'd1; W_stat = 3'd1; M_bubble = 1'b0;
    set_e(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF);
    rst_n = 1'b0;
    #12;
    checks++; if (a_Mstat !== 3'd1) begin failures++; $display("FAIL reset_Mstat got=%0d exp=1", a_Mstat); end
    checks++; if (a_Micode !== 4'h1) begin failures++; $display("FAIL reset_Micode got=%h exp=1", a_Micode); end
    checks++; if (a_MvalE !== 64'h0) begin failures++; $display("FAIL reset_MvalE got=%h exp=0", a_MvalE); end
    checks++; if (a_MdstE !== 4'hF || a_MdstM !== 4'hF) begin failures++; $display("FAIL reset_Mdst got=%h/%h exp=F/F", a_MdstE, a_MdstM); end
    checks++; if (a_cc !== 3'b100) begin failures++; $display("FAIL reset_cc got=%b exp=100", a_cc); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add_overflow();
    set_e(4'h6, 4'h0, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 4'h2);
    step();
    checks++; if (a_MvalE !== 64'h8000_0000_0000_0000) begin failures++; $display("FAIL add_valE got=%h exp=8000000000000000", a_MvalE); end
    checks++; if (a_cc !== 3'b011) begin failures++; $display("FAIL add_cc got=%b exp=011", a_cc); end
    checks++; if (a_MdstE !== 4'h2 || a_Micode !== 4'h6) begin failures++; $display("FAIL add_Mregs got=%h/%h exp=2/6", a_MdstE, a_Micode); end
    set_e(4'h7, 4'h2, 64'h0, 64'h0, 64'h400, 4'hF);
    #1;
    checks++; if (a_cnd !== 1'b0) begin failures++; $display("FAIL jl_ecnd got=%b exp=0", a_cnd); end
    step();
    checks++; if (a_Mcnd !== 1'b0 || a_Micode !== 4'h7) begin failures++; $display("FAIL jl_M got=%b/%h exp=0/7", a_Mcnd, a_Micode); end
  endtask

  task automatic test_invalid_ifun();
    set_e(4'h6, 4'h7, 64'h1, 64'h1, 64'h0, 4'h2);
    #1;
    checks++; if (a_valE !== 64'h0) begin failures++; $display("FAIL inv_evalE got=%h exp=0", a_valE); end
    step();
    checks++; if (a_Mstat !== 3'd4) begin failures++; $display("FAIL inv_Mstat got=%0d exp=4", a_Mstat); end
    checks++; if (a_cc !== 3'b011) begin failures++; $display("FAIL inv_cc got=%b exp=011", a_cc); end
  endtask

  task automatic test_sub_cmov();
    set_e(4'h6, 4'h1, 64'h5, 64'h5, 64'h0, 4'h1);
    step();
    checks++; if (a_cc !== 3'b100 || a_MvalE !== 64'h0) begin failures++; $display("FAIL sub_zero got=cc %b valE %h exp=cc 100 valE 0", a_cc, a_MvalE); end
    set_e(4'h2, 4'h3, 64'h1234, 64'h0, 64'h0, 4'h3);
    #1;
    checks++; if (a_dstE !== 4'h3 || a_cnd !== 1'b1) begin failures++; $display("FAIL cmove_e got=%h/%b exp=3/1", a_dstE, a_cnd); end
    step();
    checks++; if (a_MvalE !== 64'h1234 || a_MdstE !== 4'h3) begin failures++; $display("FAIL cmove_M got=%h/%h exp=1234/3", a_MvalE, a_MdstE); end
    set_e(4'h2, 4'h4, 64'h5678, 64'h0, 64'h0, 4'h3);
    #1;
    checks++; if (a_dstE !== 4'hF) begin failures++; $display("FAIL cmovne_e got=%h exp=F", a_dstE); end
    step();
    checks++; if (a_MdstE !== 4'hF || a_MvalE !== 64'h5678) begin failures++; $display("FAIL cmovne_M got=%h/%h exp=F/5678", a_MdstE, a_MvalE); end
  endtask

  task automatic test_cc_suppress();
    m_stat = 3'd3;
    set_e(4'h6, 4'h0, 64'h2, 64'h3, 64'h0, 4'h1);
    step();
    checks++; if (a_cc !== 3'b100) begin failures++; $display("FAIL supp_cc got=%b exp=100", a_cc); end
    checks++; if (a_MvalE !== 64'h5) begin failures++; $display("FAIL supp_valE got=%h exp=5", a_MvalE); end
    m_stat = 3'd1;
  endtask

  task automatic test_stack_addr();
    set_e(4'hA, 4'h0, 64'h0, 64'h100, 64'h0, 4'h4);
    step();
    checks++; if (a_MvalE !== 64'hF8) begin failures++; $display("FAIL pushq got=%h exp=f8", a_MvalE); end
    set_e(4'hB, 4'h0, 64'h0, 64'h100, 64'h0, 4'h4);
    step();
    checks++; if (a_MvalE !== 64'h108) begin failures++; $display("FAIL popq got=%h exp=108", a_MvalE); end
    set_e(4'h5, 4'h0, 64'h0, 64'h40, 64'h10, 4'hF);
    step();
    checks++; if (a_MvalE !== 64'h50) begin failures++; $display("FAIL mrmovq got=%h exp=50", a_MvalE); end
    set_e(4'h3, 4'h0, 64'h0, 64'h0, 64'hDEAD, 4'h2);
    step();
    checks++; if (a_MvalE !== 64'hDEAD) begin failures++; $display("FAIL irmovq got=%h exp=dead", a_MvalE); end
    M_bubble = 1'b1;
    set_e(4'h6, 4'h0, 64'h2, 64'h3, 64'h0, 4'h1);
    step();
    checks++; if (a_Micode !== 4'h1 || a_MvalE !== 64'h0 || a_MdstE !== 4'hF) begin failures++; $display("FAIL bubble got=%h/%h/%h exp=1/0/F", a_Micode, a_MvalE, a_MdstE); end
    M_bubble = 1'b0;
  endtask

  task automatic test_mul16();
    int n, nb;
    set_e(4'h6, 4'h4, 64'hFFFF_FFFF_FFFF_FFFD, 64'h7, 64'h0, 4'h4);
    #1;
    checks++; if (b_busy !== 1'b1 || c_busy !== 1'b0) begin failures++; $display("FAIL mul_busy0 got=%b/%b exp=1/0", b_busy, c_busy); end
    wait_busy16(n, nb);
    checks++; if (n != 17) begin failures++; $display("FAIL mul_busy_cycles got=%0d exp=17", n); end
    checks++; if (nb != 0) begin failures++; $display("FAIL mul_bubbles got=%0d nonbubble exp=0", nb); end
    checks++; if (c_Mstat !== 3'd4 || c_MvalE !== 16'h0) begin failures++; $display("FAIL nomul got=%0d/%h exp=4/0", c_Mstat, c_MvalE); end
    checks++; if (b_valE !== 16'hFFEB) begin failures++; $display("FAIL mul_evalE got=%h exp=ffeb", b_valE); end
    step();
    set_e(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF);
    checks++; if (b_MvalE !== 16'hFFEB || b_Micode !== 4'h6 || b_MdstE !== 4'h4) begin failures++; $display("FAIL mul_M got=%h/%h/%h exp=ffeb/6/4", b_MvalE, b_Micode, b_MdstE); end
    checks++; if (b_cc !== 3'b010) begin failures++; $display("FAIL mul_cc got=%b exp=010", b_cc); end
    step();
  endtask

  task automatic test_reset_mid_mul();
    int n, nb;
    set_e(4'h6, 4'h4, 64'h6, 64'hFFFF_FFFF_FFFF_FFFB, 64'h0, 4'h5);
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    checks++; if (b_busy !== 1'b0) begin failures++; $display("FAIL rstmul_busy got=%b exp=0", b_busy); end
    checks++; if (b_cc !== 3'b100) begin failures++; $display("FAIL rstmul_cc got=%b exp=100", b_cc); end
    checks++; if (b_Micode !== 4'h1 || b_MvalE !== 16'h0) begin failures++; $display("FAIL rstmul_M got=%h/%h exp=1/0", b_Micode, b_MvalE); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    wait_busy16(n, nb);
    checks++; if (n != 17) begin failures++; $display("FAIL rstmul_cycles got=%0d exp=17", n); end
    step();
    set_e(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF);
    checks++; if (b_MvalE !== 16'hFFE2 || b_MdstE !== 4'h5) begin failures++; $display("FAIL rstmul_result got=%h/%h exp=ffe2/5", b_MvalE, b_MdstE); end
    checks++; if (b_cc !== 3'b010) begin failures++; $display("FAIL rstmul_resultcc got=%b exp=010", b_cc); end
    step();
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_invalid_ifun();
    test_sub_cmov();
    test_cc_suppress();
    test_stack_addr();
    test_mul16();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
